// File: rtl/id_ex_alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_alu_issue_pkg : shared ALU control codes and MIPS opcode/funct values
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package id_ex_alu_issue_pkg;

   localparam logic [2:0] ALU_CTRL_AND = 3'd0;
   localparam logic [2:0] ALU_CTRL_OR  = 3'd1;
   localparam logic [2:0] ALU_CTRL_ADD = 3'd2;
   localparam logic [2:0] ALU_CTRL_NOR = 3'd4;
   localparam logic [2:0] ALU_CTRL_SUB = 3'd6;
   localparam logic [2:0] ALU_CTRL_NOP = 3'd7;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;

endpackage

`default_nettype wire

// File: rtl/id_ex_alu_issue_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux : operand forwarding select, EX/MEM over MEM/WB over register file
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_mux #(
   parameter int LEN = 32
) (
   input  logic [4:0]     idx_i,
   input  logic [LEN-1:0] rf_data_i,
   input  logic           exmem_wr_en_i,
   input  logic [4:0]     exmem_rd_i,
   input  logic [LEN-1:0] exmem_val_i,
   input  logic           memwb_wr_en_i,
   input  logic [4:0]     memwb_rd_i,
   input  logic [LEN-1:0] memwb_val_i,
   output logic [LEN-1:0] data_o
);

   always_comb begin
      data_o = rf_data_i;
      // Register 0 is hardwired, so a stage "writing" it must never be forwarded
      if (idx_i != 5'd0) begin
         if (exmem_wr_en_i && (exmem_rd_i == idx_i)) begin
            data_o = exmem_val_i;
         end else if (memwb_wr_en_i && (memwb_rd_i == idx_i)) begin
            data_o = memwb_val_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// id_ex_alu_issue : ID/EX decode, forwarding and registered ALU issue bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_alu_issue
   import id_ex_alu_issue_pkg::*;
#(
   parameter int LEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           id_valid,
   input  logic [5:0]     opcode,
   input  logic [5:0]     funct,
   input  logic [4:0]     rs_idx,
   input  logic [4:0]     rt_idx,
   input  logic [4:0]     rd_idx,
   input  logic [LEN-1:0] rs_data,
   input  logic [LEN-1:0] rt_data,
   input  logic [15:0]    imm16,
   input  logic           exmem_wr_en,
   input  logic [4:0]     exmem_rd,
   input  logic [LEN-1:0] exmem_val,
   input  logic           memwb_wr_en,
   input  logic [4:0]     memwb_rd,
   input  logic [LEN-1:0] memwb_val,
   input  logic           stall,
   input  logic           flush,
   output logic           ex_valid,
   output logic [LEN-1:0] num_1,
   output logic [LEN-1:0] num_2,
   output logic [2:0]     alu_ctrl,
   output logic [4:0]     ex_rd,
   output logic           ex_wr_en,
   output logic [LEN-1:0] ex_store_data,
   output logic           ex_is_branch
);

   logic [LEN-1:0] rs_fwd, rt_fwd, imm_ext;
   logic [2:0]     alu_d;
   logic [4:0]     dest_d;
   logic           wr_d, use_imm_d, sext_d, br_d;

   logic           valid_q, wr_q, br_q;
   logic [LEN-1:0] num1_q, num2_q, sd_q;
   logic [2:0]     alu_q;
   logic [4:0]     rd_q;

   fwd_mux #(.LEN(LEN)) u_fwd_rs (
      .idx_i(rs_idx), .rf_data_i(rs_data),
      .exmem_wr_en_i(exmem_wr_en), .exmem_rd_i(exmem_rd), .exmem_val_i(exmem_val),
      .memwb_wr_en_i(memwb_wr_en), .memwb_rd_i(memwb_rd), .memwb_val_i(memwb_val),
      .data_o(rs_fwd)
   );

   fwd_mux #(.LEN(LEN)) u_fwd_rt (
      .idx_i(rt_idx), .rf_data_i(rt_data),
      .exmem_wr_en_i(exmem_wr_en), .exmem_rd_i(exmem_rd), .exmem_val_i(exmem_val),
      .memwb_wr_en_i(memwb_wr_en), .memwb_rd_i(memwb_rd), .memwb_val_i(memwb_val),
      .data_o(rt_fwd)
   );

   always_comb begin
      alu_d     = ALU_CTRL_NOP;
      wr_d      = 1'b0;
      use_imm_d = 1'b1;
      sext_d    = 1'b1;
      br_d      = 1'b0;
      dest_d    = rt_idx;
      case (opcode)
         OP_RTYPE: begin
            use_imm_d = 1'b0;
            dest_d    = rd_idx;
            wr_d      = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: alu_d = ALU_CTRL_ADD;
               FN_SUB, FN_SUBU: alu_d = ALU_CTRL_SUB;
               FN_AND:          alu_d = ALU_CTRL_AND;
               FN_OR:           alu_d = ALU_CTRL_OR;
               FN_NOR:          alu_d = ALU_CTRL_NOR;
               default:         wr_d  = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW: begin
            alu_d = ALU_CTRL_ADD;
            wr_d  = 1'b1;
         end
         OP_ANDI: begin
            alu_d  = ALU_CTRL_AND;
            sext_d = 1'b0;
            wr_d   = 1'b1;
         end
         OP_ORI: begin
            alu_d  = ALU_CTRL_OR;
            sext_d = 1'b0;
            wr_d   = 1'b1;
         end
         OP_SW:   alu_d = ALU_CTRL_ADD;
         OP_BEQ: begin
            alu_d     = ALU_CTRL_SUB;
            use_imm_d = 1'b0;
            br_d      = 1'b1;
         end
         default: alu_d = ALU_CTRL_NOP;
      endcase
   end

   assign imm_ext = sext_d ? LEN'($signed(imm16)) : LEN'(imm16);

   always_ff @(posedge clk) begin
      if (!rst_n || flush || (!stall && !id_valid)) begin
         valid_q <= 1'b0;
         num1_q  <= '0;
         num2_q  <= '0;
         sd_q    <= '0;
         alu_q   <= ALU_CTRL_NOP;
         rd_q    <= 5'd0;
         wr_q    <= 1'b0;
         br_q    <= 1'b0;
      end else if (!stall) begin
         valid_q <= 1'b1;
         num1_q  <= rs_fwd;
         num2_q  <= use_imm_d ? imm_ext : rt_fwd;
         sd_q    <= rt_fwd;
         alu_q   <= alu_d;
         rd_q    <= dest_d;
         wr_q    <= wr_d && (dest_d != 5'd0);
         br_q    <= br_d;
      end
   end

   assign ex_valid      = valid_q;
   assign num_1         = num1_q;
   assign num_2         = num2_q;
   assign ex_store_data = sd_q;
   assign alu_ctrl      = alu_q;
   assign ex_rd         = rd_q;
   assign ex_wr_en      = wr_q;
   assign ex_is_branch  = br_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_id_ex_alu_issue : directed and randomized checks against a bundle model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_alu_issue;
   import id_ex_alu_issue_pkg::*;

   typedef struct packed {
      logic        v;
      logic [31:0] n1;
      logic [31:0] n2;
      logic [2:0]  ctl;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] sd;
      logic        br;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst_n, id_valid, exmem_wr_en, memwb_wr_en, stall, flush;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs_idx, rt_idx, rd_idx, exmem_rd, memwb_rd;
   logic [31:0] rs_data, rt_data, exmem_val, memwb_val;
   logic [15:0] imm16;
   logic        ex_valid, ex_wr_en, ex_is_branch;
   logic [31:0] num_1, num_2, ex_store_data;
   logic [2:0]  alu_ctrl;
   logic [4:0]  ex_rd;

   int checks = 0;
   int failures = 0;
   bundle_t bubble;

   id_ex_alu_issue #(.LEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
      .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .rs_data(rs_data), .rt_data(rt_data),
      .imm16(imm16), .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .num_1(num_1), .num_2(num_2),
      .alu_ctrl(alu_ctrl), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
      .ex_store_data(ex_store_data), .ex_is_branch(ex_is_branch)
   );

   always #5 clk = ~clk;

   function automatic bundle_t observed();
      return '{ex_valid, num_1, num_2, alu_ctrl, ex_rd, ex_wr_en, ex_store_data, ex_is_branch};
   endfunction

   // Value a register read resolves to once in-flight results are taken into account
   function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 0) return rf;
      if (exmem_wr_en && exmem_rd == idx) return exmem_val;
      if (memwb_wr_en && memwb_rd == idx) return memwb_val;
      return rf;
   endfunction

   // Instruction-level meaning of the current ID inputs
   function automatic bundle_t model_decode();
      bundle_t b;
      logic [31:0] a, b_reg, simm, zimm;
      bit writes, reg_op;
      logic [4:0] dst;
      a      = resolve(rs_idx, rs_data);
      b_reg  = resolve(rt_idx, rt_data);
      simm   = {{16{imm16[15]}}, imm16};
      zimm   = {16'h0, imm16};
      b      = '{1'b1, a, simm, ALU_CTRL_NOP, rt_idx, 1'b0, b_reg, 1'b0};
      writes = 0;
      reg_op = 0;
      dst    = rt_idx;
      if (opcode == 6'h00) begin
         reg_op = 1;
         dst    = rd_idx;
         writes = 1;
         if (funct == 6'h20 || funct == 6'h21)      b.ctl = ALU_CTRL_ADD;
         else if (funct == 6'h22 || funct == 6'h23) b.ctl = ALU_CTRL_SUB;
         else if (funct == 6'h24)                   b.ctl = ALU_CTRL_AND;
         else if (funct == 6'h25)                   b.ctl = ALU_CTRL_OR;
         else if (funct == 6'h27)                   b.ctl = ALU_CTRL_NOR;
         else                                       writes = 0;
      end else if (opcode == 6'h08 || opcode == 6'h09 || opcode == 6'h23) begin
         b.ctl = ALU_CTRL_ADD; writes = 1;
      end else if (opcode == 6'h0C) begin
         b.ctl = ALU_CTRL_AND; b.n2 = zimm; writes = 1;
      end else if (opcode == 6'h0D) begin
         b.ctl = ALU_CTRL_OR; b.n2 = zimm; writes = 1;
      end else if (opcode == 6'h2B) begin
         b.ctl = ALU_CTRL_ADD;
      end else if (opcode == 6'h04) begin
         b.ctl = ALU_CTRL_SUB; reg_op = 1; b.br = 1'b1;
      end
      if (reg_op) b.n2 = b_reg;
      b.rd = dst;
      b.wr = writes && dst != 0;
      if (!id_valid) b = bubble;
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rst_n = 1; id_valid = 1; stall = 0; flush = 0;
      opcode = 0; funct = 6'h20; rs_idx = 1; rt_idx = 2; rd_idx = 3;
      rs_data = 0; rt_data = 0; imm16 = 0;
      exmem_wr_en = 0; exmem_rd = 0; exmem_val = 0;
      memwb_wr_en = 0; memwb_rd = 0; memwb_val = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rs_data = 32'h1234; rt_data = 32'h55;
      step();
      rst_n = 0;
      step();
      checks++;
      if (observed() !== bubble) begin
         failures++;
         $display("FAIL reset: got %h want %h", observed(), bubble);
      end
      stall = 1; flush = 1;
      step();
      checks++;
      if (ex_valid !== 1'b0 || alu_ctrl !== ALU_CTRL_NOP || num_1 !== 32'd0) begin
         failures++;
         $display("FAIL reset_over_stall: got valid=%b ctl=%h n1=%h want 0/%h/0",
                  ex_valid, alu_ctrl, num_1, ALU_CTRL_NOP);
      end
      clear_inputs();
   endtask

   task automatic test_rtype_add();
      clear_inputs();
      rs_data = 5; rt_data = 7; rd_idx = 3;
      step();
      checks++;
      if (num_1 !== 32'd5 || num_2 !== 32'd7 || alu_ctrl !== ALU_CTRL_ADD ||
          ex_rd !== 5'd3 || ex_wr_en !== 1'b1 || ex_valid !== 1'b1) begin
         failures++;
         $display("FAIL rtype_add: got n1=%0d n2=%0d ctl=%h rd=%0d wr=%b v=%b want 5 7 %h 3 1 1",
                  num_1, num_2, alu_ctrl, ex_rd, ex_wr_en, ex_valid, ALU_CTRL_ADD);
      end
   endtask

   task automatic test_imm_ext();
      clear_inputs();
      opcode = OP_ADDI; imm16 = 16'hFFFF; rt_idx = 4;
      step();
      checks++;
      if (num_2 !== 32'hFFFF_FFFF || alu_ctrl !== ALU_CTRL_ADD) begin
         failures++;
         $display("FAIL addi_sext: got n2=%h ctl=%h want ffffffff %h", num_2, alu_ctrl, ALU_CTRL_ADD);
      end
      opcode = OP_ORI;
      step();
      checks++;
      if (num_2 !== 32'h0000_FFFF || alu_ctrl !== ALU_CTRL_OR) begin
         failures++;
         $display("FAIL ori_zext: got n2=%h ctl=%h want 0000ffff %h", num_2, alu_ctrl, ALU_CTRL_OR);
      end
      opcode = OP_ANDI; imm16 = 16'h8001;
      step();
      checks++;
      if (num_2 !== 32'h0000_8001 || alu_ctrl !== ALU_CTRL_AND) begin
         failures++;
         $display("FAIL andi_zext: got n2=%h ctl=%h want 00008001 %h", num_2, alu_ctrl, ALU_CTRL_AND);
      end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      rs_idx = 4; rs_data = 32'h11;
      exmem_wr_en = 1; exmem_rd = 4; exmem_val = 32'hAA;
      memwb_wr_en = 1; memwb_rd = 4; memwb_val = 32'hBB;
      step();
      checks++;
      if (num_1 !== 32'hAA) begin
         failures++;
         $display("FAIL fwd_exmem_priority: got %h want 000000aa", num_1);
      end
      exmem_wr_en = 0;
      step();
      checks++;
      if (num_1 !== 32'hBB) begin
         failures++;
         $display("FAIL fwd_memwb: got %h want 000000bb", num_1);
      end
      exmem_wr_en = 1; rs_idx = 0; exmem_rd = 0; memwb_rd = 0;
      step();
      checks++;
      if (num_1 !== 32'h11) begin
         failures++;
         $display("FAIL fwd_r0: got %h want 00000011", num_1);
      end
      rs_idx = 1; rt_idx = 6; rt_data = 32'h22; memwb_rd = 6; exmem_rd = 9;
      opcode = OP_SW;
      step();
      checks++;
      if (ex_store_data !== 32'hBB || ex_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL fwd_store_data: got sd=%h wr=%b want 000000bb 0", ex_store_data, ex_wr_en);
      end
   endtask

   task automatic test_stall_flush();
      clear_inputs();
      funct = FN_SUB; rs_data = 9; rt_data = 2; rd_idx = 5;
      step();
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         funct = FN_OR; rs_data = $urandom; rt_data = $urandom; rd_idx = 5'(k + 10);
         step();
         checks++;
         if (alu_ctrl !== ALU_CTRL_SUB || num_1 !== 32'd9 || num_2 !== 32'd2 || ex_rd !== 5'd5) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got ctl=%h n1=%0d n2=%0d rd=%0d want %h 9 2 5",
                     k, alu_ctrl, num_1, num_2, ex_rd, ALU_CTRL_SUB);
         end
      end
      flush = 1;
      step();
      checks++;
      if (observed() !== bubble) begin
         failures++;
         $display("FAIL flush_over_stall: got %h want %h", observed(), bubble);
      end
   endtask

   task automatic test_zero_dest_beq();
      clear_inputs();
      opcode = OP_ADDI; rt_idx = 0; imm16 = 16'd3;
      step();
      checks++;
      if (ex_wr_en !== 1'b0 || ex_valid !== 1'b1) begin
         failures++;
         $display("FAIL zero_dest: got wr=%b v=%b want 0 1", ex_wr_en, ex_valid);
      end
      opcode = OP_BEQ; rt_idx = 2; rs_data = 8; rt_data = 8;
      step();
      checks++;
      if (alu_ctrl !== ALU_CTRL_SUB || ex_is_branch !== 1'b1 || ex_wr_en !== 1'b0 || num_2 !== 32'd8) begin
         failures++;
         $display("FAIL beq: got ctl=%h br=%b wr=%b n2=%0d want %h 1 0 8",
                  alu_ctrl, ex_is_branch, ex_wr_en, num_2, ALU_CTRL_SUB);
      end
   endtask

   task automatic test_random();
      bundle_t exp;
      logic [5:0] ops [9];
      logic [5:0] fns [8];
      ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h26};
      clear_inputs();
      rst_n = 0;
      step();
      exp = bubble;
      for (int n = 0; n < 300; n++) begin
         rst_n       = ($urandom_range(0, 39) != 0);
         id_valid    = ($urandom_range(0, 5) != 0);
         stall       = ($urandom_range(0, 4) == 0);
         flush       = ($urandom_range(0, 9) == 0);
         opcode      = ($urandom_range(0, 12) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
         funct       = fns[$urandom_range(0, 7)];
         rs_idx      = 5'($urandom_range(0, 7));
         rt_idx      = 5'($urandom_range(0, 7));
         rd_idx      = 5'($urandom_range(0, 7));
         rs_data     = $urandom;
         rt_data     = $urandom;
         imm16       = 16'($urandom);
         exmem_wr_en = 1'($urandom);
         exmem_rd    = 5'($urandom_range(0, 7));
         exmem_val   = $urandom;
         memwb_wr_en = 1'($urandom);
         memwb_rd    = 5'($urandom_range(0, 7));
         memwb_val   = $urandom;
         if (!rst_n || flush) exp = bubble;
         else if (!stall)     exp = model_decode();
         step();
         checks++;
         if (observed() !== exp) begin
            failures++;
            $display("FAIL random[%0d]: got %h want %h", n, observed(), exp);
         end
      end
   endtask

   initial begin
      bubble = '{1'b0, 32'd0, 32'd0, ALU_CTRL_NOP, 5'd0, 1'b0, 32'd0, 1'b0};
      test_reset();
      test_rtype_add();
      test_imm_ext();
      test_forwarding();
      test_stall_flush();
      test_zero_dest_beq();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
